sn_count: RTL and testbench

SN_COUNT -- requirements
Module: sn_count

---
 rtl/sn_count.sv | 137 +++++++++++++
 tb/tb_sn_count.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sn_count.sv
// Stochastic-number window counter: decodes a unipolar, bipolar or two-line bit stream into a signed count.
// Optional continuous back-to-back windows when SN_COUNT_CONT_EN is defined.
module sn_count #(
    parameter logic [1:0] MODE = 2'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        SN_IN_P,
    input  logic        SN_IN_N,
    input  logic [31:0] DATA_IN,
    input  logic        LEN_WE,
    input  logic        START,
    output logic [31:0] DATA_OUT,
    output logic        VALID,
    output logic        BUSY
);

`ifdef SN_COUNT_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [30:0] len;
    logic [30:0] len_nxt;
    logic [30:0] wlen;
    logic [30:0] cnt;
    logic [31:0] acc;
    logic [31:0] delta;
    logic [31:0] acc_add;
    logic [31:0] acc_fin;
    logic [31:0] result;
    logic        go;
    logic        last;
    logic        unused_msb;

    assign unused_msb = DATA_IN[31];

    // A write in the same cycle as START must be the length that gets latched.
    assign len_nxt = LEN_WE ? DATA_IN[30:0] : len;
    assign go      = START && (state != S_RUN);

    always_comb begin
        delta = {31'd0, SN_IN_P};
        if (MODE >= 2'd2) begin
            delta = {31'd0, SN_IN_P} - {31'd0, SN_IN_N};
        end
    end

    assign acc_add = acc + delta;

    // A zero-length window closes on the first RUN cycle without counting.
    assign last = (state == S_RUN)
               && ((wlen == 31'd0) || (EN && (cnt == wlen - 31'd1)));

    assign acc_fin = (wlen == 31'd0) ? acc : acc_add;

    always_comb begin
        result = acc_fin;
        if (MODE == 2'd1) begin
            result = {acc_fin[30:0], 1'b0} - {1'b0, wlen};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (START) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last) state_nxt = CONT ? S_RUN : S_DONE;
            end
            S_DONE: begin
                if (START) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            len      <= 31'd0;
            wlen     <= 31'd0;
            cnt      <= 31'd0;
            acc      <= 32'd0;
            DATA_OUT <= 32'd0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            len <= len_nxt;
            if (CONT) begin
                VALID <= 1'b0;
            end
            if (go) begin
                wlen  <= len_nxt;
                cnt   <= 31'd0;
                acc   <= 32'd0;
                VALID <= 1'b0;
                BUSY  <= 1'b1;
            end else if (state == S_RUN) begin
                if (last) begin
                    DATA_OUT <= result;
                    VALID    <= 1'b1;
                    if (CONT) begin
                        wlen <= len_nxt;
                        cnt  <= 31'd0;
                        acc  <= 32'd0;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end else if (EN) begin
                    acc <= acc_add;
                    cnt <= cnt + 31'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sn_count.sv
// Bench for sn_count: all four MODE values side by side, directed windows plus random streams
// checked against a per-window sum model.
module tb_sn_count;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        SN_IN_P;
    logic        SN_IN_N;
    logic [31:0] DATA_IN;
    logic        LEN_WE;
    logic        START;
    logic [31:0] dout [4];
    logic        vld  [4];
    logic        bsy  [4];

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sn_count #(.MODE(2'(g))) u_dut (
            .CLK     (CLK),
            .RST     (RST),
            .EN      (EN),
            .SN_IN_P (SN_IN_P),
            .SN_IN_N (SN_IN_N),
            .DATA_IN (DATA_IN),
            .LEN_WE  (LEN_WE),
            .START   (START),
            .DATA_OUT(dout[g]),
            .VALID   (vld[g]),
            .BUSY    (bsy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Result as a signed number of the window's counted samples.
    function automatic logic [31:0] model(input int mode, input int ones,
                                          input int nsum, input int wlen);
        int r;
        if (mode == 0) r = ones;
        else if (mode == 1) r = 2 * ones - wlen;
        else r = ones - nsum;
        return 32'(r);
    endfunction

    task automatic chk_all(input string tag, input logic ev, input logic eb,
                           input int ones, input int nsum, input int wlen,
                           input bit cd);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.m%0d.valid", tag, i), {31'd0, vld[i]}, {31'd0, ev});
            chk($sformatf("%s.m%0d.busy", tag, i), {31'd0, bsy[i]}, {31'd0, eb});
            if (cd) chk($sformatf("%s.m%0d.data", tag, i), dout[i],
                        model(i, ones, nsum, wlen));
        end
    endtask

    task automatic cyc(input logic en, input logic p, input logic n,
                       input logic st, input logic we, input logic [31:0] din);
        EN      = en;
        SN_IN_P = p;
        SN_IN_N = n;
        START   = st;
        LEN_WE  = we;
        DATA_IN = din;
        @(posedge CLK);
        #1;
    endtask

    // kind 0: random EN/P/N; 1: EN=1 with P/N from pv/nv; 2: EN on odd cycles
    task automatic window(input string tag, input int len, input int kind,
                          input logic [31:0] pv, input logic [31:0] nv,
                          input bit disturb);
        int k = 0;
        int ones = 0;
        int nsum = 0;
        int cn = 0;
        logic en, p, n, st, we;
        logic [31:0] din;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'(len) | 32'h8000_0000);
        chk_all({tag, ".start"}, 1'b0, 1'b1, 0, 0, len, 1'b0);
        if (len == 0) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        while (k < len && cn < 4 * len + 8) begin
            p = 1'($urandom_range(0, 1));
            n = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            if (kind == 1) begin
                en = 1'b1;
                p = pv[k];
                n = nv[k];
            end else if (kind == 2) begin
                en = (cn % 2 == 1);
            end
            st = 1'b0;
            we = 1'b0;
            din = 32'd0;
            if (disturb && cn == 5) begin
                st = 1'b1;
                we = 1'b1;
                din = 32'd3;
            end
            cyc(en, p, n, st, we, din);
            cn++;
            if (en) begin
                k++;
                ones += int'(p);
                nsum += int'(n);
            end
            if (k < len) chk_all({tag, ".run"}, 1'b0, 1'b1, 0, 0, len, 1'b0);
        end
        if (k < len) chk({tag, ".timeout"}, 32'(k), 32'(len));
        if (kind == 2) chk({tag, ".cycles"}, 32'(cn), 32'(2 * len));
        chk_all({tag, ".done"}, 1'b1, 1'b0, ones, nsum, len, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk_all({tag, ".hold"}, 1'b1, 1'b0, ones, nsum, len, 1'b1);
    endtask

    initial begin
        RST = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        RST = 1'b0;
        chk_all("reset", 1'b0, 1'b0, 0, 0, 0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        chk_all("idle", 1'b0, 1'b0, 0, 0, 0, 1'b1);

`ifdef SN_COUNT_CONT_EN
        begin
            logic [31:0] prev [4];
            logic en, p, n;
            for (int i = 0; i < 4; i++) prev[i] = 32'd0;
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4);
            chk_all("cont.start", 1'b0, 1'b1, 0, 0, 4, 1'b0);
            for (int w = 0; w < 5; w++) begin
                int k = 0;
                int ones = 0;
                int nsum = 0;
                int cn = 0;
                while (k < 4 && cn < 40) begin
                    en = (w == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    p = (w == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    n = 1'($urandom_range(0, 1));
                    cyc(en, p, n, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
                    cn++;
                    if (en) begin
                        k++;
                        ones += int'(p);
                        nsum += int'(n);
                    end
                    if (k < 4) begin
                        chk_all("cont.run", 1'b0, 1'b1, 0, 0, 4, 1'b0);
                        for (int i = 0; i < 4; i++)
                            chk($sformatf("cont.held.m%0d", i), dout[i], prev[i]);
                    end
                end
                if (k < 4) chk("cont.timeout", 32'(k), 32'd4);
                chk_all($sformatf("cont.w%0d", w), 1'b1, 1'b1, ones, nsum, 4, 1'b1);
                for (int i = 0; i < 4; i++) prev[i] = model(i, ones, nsum, 4);
            end
        end
`else
        window("m0_len16", 16, 1, 32'h0000_0FFF, 32'h0000_0000, 1'b0);
        window("len8_zeros", 8, 1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        window("len8_ones", 8, 1, 32'h0000_00FF, 32'h0000_00FF, 1'b0);
        window("len4_pn", 4, 1, 32'h0000_0005, 32'h0000_000E, 1'b0);
        window("len10_alt", 10, 2, 32'd0, 32'd0, 1'b1);
        window("len0", 0, 0, 32'd0, 32'd0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            window($sformatf("rand%0d", r), int'($urandom_range(1, 24)), 0,
                   32'd0, 32'd0, 1'b0);
        end
`endif

        RST = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd10);
        RST = 1'b1;
        for (int c = 0; c < 3; c++) RST = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        chk_all("pre_abort", 1'b0, 1'b1, 0, 0, 10, 1'b0);
        RST = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2);
        RST = 1'b0;
        chk_all("abort", 1'b0, 1'b0, 0, 0, 0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        chk_all("abort_no_valid", 1'b0, 1'b0, 0, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
